// File: rtl/delay_cal_pkg.sv
// Shared types and constants for the delay-line tap calibration sequencer.
// Imported by the synchroniser and the top-level FSM.
package delay_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    FIRE,
    SYNC,
    EVAL
  } cal_state_t;

  localparam int SYNC_CYC = 2;

endpackage

// File: rtl/delay_tap_cal_sync2.sv
// Two-flop synchroniser bringing the asynchronous tap output into clk.
// Both stages reset to the chain's settled value.
module sync2
  import delay_cal_pkg::*;
#(
  parameter logic RVAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= RVAL;
      ff2_q <= RVAL;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/delay_tap_cal.sv
// Calibration sequencer: resets the delay chain, launches an edge, samples
// the selected tap and sweeps upward to lock on the last contiguous good tap.
module delay_tap_cal
  import delay_cal_pkg::*;
#(
  parameter int   NTAPS    = 8,
  parameter int   NTRIAL   = 4,
  parameter int   RST_CYC  = 2,
  parameter int   WAIT_CYC = 3,
  parameter logic RVAL     = 1'b0,
  parameter logic RPOL     = 1'b0,
  localparam int  TW       = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          locked,
  output logic          err,
  output logic [TW-1:0] tap,
  output logic [TW-1:0] tap_sel,
  output logic          chain_rst,
  output logic          launch,
  input  logic          sample_async
);

  localparam int MAXC = (RST_CYC > WAIT_CYC) ? RST_CYC : WAIT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  cal_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    trial_q, trial_d;
  logic [TW-1:0] tap_sel_q, tap_sel_d;
  logic [TW-1:0] tap_q, tap_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          chain_rst_q, chain_rst_d;
  logic          launch_q, launch_d;
  logic          pass_q, pass_d;
  logic          samp_s;

  sync2 #(.RVAL(RVAL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sample_async),
    .q   (samp_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trial_d     = trial_q;
    tap_sel_d   = tap_sel_q;
    tap_d       = tap_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    locked_d    = locked_q;
    err_d       = err_q;
    chain_rst_d = chain_rst_q;
    launch_d    = launch_q;
    pass_d      = pass_q;
    unique case (state_q)
      IDLE: begin
        chain_rst_d = RPOL;
        launch_d    = RVAL;
        if (start) begin
          locked_d  = 1'b0;
          err_d     = 1'b0;
          tap_sel_d = '0;
          trial_d   = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = CRST;
        end
      end
      CRST: begin
        if (cnt_q == CW'(RST_CYC - 1)) begin
          cnt_d       = '0;
          chain_rst_d = ~RPOL;
          launch_d    = ~RVAL;
          state_d     = FIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: begin
        if (cnt_q == CW'(WAIT_CYC - 1)) begin
          cnt_d   = '0;
          state_d = SYNC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SYNC: begin
        // Let the synchroniser flush the fresh sample before judging it.
        if (cnt_q == CW'(SYNC_CYC - 1)) begin
          cnt_d       = '0;
          pass_d      = (samp_s == ~RVAL);
          chain_rst_d = RPOL;
          launch_d    = RVAL;
          state_d     = EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EVAL: begin
        if (pass_q && trial_q < 8'(NTRIAL - 1)) begin
          trial_d = trial_q + 8'd1;
          state_d = CRST;
        end else if (pass_q && tap_sel_q != TW'(NTAPS - 1)) begin
          tap_sel_d = tap_sel_q + 1'b1;
          trial_d   = '0;
          state_d   = CRST;
        end else begin
          if (pass_q) begin
            tap_d    = TW'(NTAPS - 1);
            locked_d = 1'b1;
          end else if (tap_sel_q == '0) begin
            tap_d = '0;
            err_d = 1'b1;
          end else begin
            tap_d    = tap_sel_q - 1'b1;
            locked_d = 1'b1;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        chain_rst_d = RPOL;
        launch_d    = RVAL;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      trial_q     <= '0;
      tap_sel_q   <= '0;
      tap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      chain_rst_q <= RPOL;
      launch_q    <= RVAL;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trial_q     <= trial_d;
      tap_sel_q   <= tap_sel_d;
      tap_q       <= tap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      chain_rst_q <= chain_rst_d;
      launch_q    <= launch_d;
      pass_q      <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign tap       = tap_q;
  assign tap_sel   = tap_sel_q;
  assign chain_rst = chain_rst_q;
  assign launch    = launch_q;

endmodule

// File: tb/tb_delay_tap_cal.sv
// Scoreboard bench for delay_tap_cal: a delay-line model answers each
// launch, expected run results are queued and checked on every done.
module tb_delay_tap_cal;

  localparam logic RVAL = 1'b0;
  localparam logic RPOL = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, locked, err;
  logic [2:0] tap, tap_sel;
  logic       chain_rst, launch;
  logic       sample_async;

  delay_tap_cal dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .locked       (locked),
    .err          (err),
    .tap          (tap),
    .tap_sel      (tap_sel),
    .chain_rst    (chain_rst),
    .launch       (launch),
    .sample_async (sample_async)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic        er;
    int          tp;
    int          tsel;
    int          cyc;
    logic [31:0] pt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   k_lim  = 7;
  logic inject = 1'b0;

  int   pertap[8];
  int   cyc_cnt;
  logic prev_launch;
  logic prev_done;

  // Delay-line model: taps up to k_lim see the edge in time.
  always_comb begin
    sample_async = RVAL;
    if (launch == ~RVAL && int'(tap_sel) <= k_lim &&
        !(inject && tap_sel == 3'd3 && pertap[3] == 3))
      sample_async = ~RVAL;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic lk, input logic er, input int tp,
                          input int tsel, input int cyc,
                          input logic [31:0] pt);
    exp_t e;
    e.lk = lk; e.er = er; e.tp = tp;
    e.tsel = tsel; e.cyc = cyc; e.pt = pt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      foreach (pertap[i]) pertap[i] = 0;
      cyc_cnt     = 0;
      prev_launch = RVAL;
      prev_done   = 1'b0;
    end else begin
      if (busy) cyc_cnt++;
      if (launch == ~RVAL && prev_launch == RVAL) pertap[tap_sel]++;
      prev_launch = launch;
      checks++;
      if ((chain_rst == RPOL && launch != RVAL) || (locked && err) ||
          (!busy && chain_rst != RPOL) || (done && prev_done)) begin
        errors++;
        $display("FAIL invariant: rst=%b launch=%b lk=%b er=%b busy=%b done=%b",
                 chain_rst, launch, locked, err, busy, done);
      end
      prev_done = done;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          logic [31:0] got;
          e = exp_q.pop_front();
          got = '0;
          for (int i = 0; i < 8; i++) got[4*i +: 4] = 4'(pertap[i]);
          chk("locked", int'(locked), int'(e.lk));
          chk("err", int'(err), int'(e.er));
          chk("tap", int'(tap), e.tp);
          chk("tap_sel_hold", int'(tap_sel), e.tsel);
          chk("busy_at_done", int'(busy), 0);
          chk("busy_cycles", cyc_cnt, e.cyc);
          chk("trials_per_tap", int'(got), int'(e.pt));
        end
        foreach (pertap[i]) pertap[i] = 0;
        cyc_cnt = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("timeout_run", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("timeout_done", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_tap", int'(tap), 0);
    chk("rst_tap_sel", int'(tap_sel), 0);
    chk("rst_chain_rst", int'(chain_rst), int'(RPOL));
    chk("rst_launch", int'(launch), int'(RVAL));
    rst = 1'b0;
    @(negedge clk);

    // 1: taps 0..4 good
    k_lim = 4;
    push_exp(1, 0, 4, 5, 168, 32'h0014_4444);
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    wait_empty();

    // 2: all taps good
    k_lim = 7;
    push_exp(1, 0, 7, 7, 256, 32'h4444_4444);
    pulse_start();
    wait_empty();

    // 3: tap 0 bad
    k_lim = -1;
    push_exp(0, 1, 0, 0, 8, 32'h0000_0001);
    pulse_start();
    wait_empty();

    // 4: tap 3 fails only its third trial
    k_lim  = 3;
    inject = 1'b1;
    push_exp(1, 0, 2, 3, 120, 32'h0000_3444);
    pulse_start();
    wait_empty();
    inject = 1'b0;

    // 5: abort in FIRE of tap 2, then rerun
    k_lim = 7;
    pulse_start();
    n = 0;
    while (!(tap_sel == 3'd2 && launch == ~RVAL) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("timeout_tap2", 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_chain_rst", int'(chain_rst), int'(RPOL));
    chk("abort_launch", int'(launch), int'(RVAL));
    chk("abort_busy", int'(busy), 0);
    chk("abort_tap_sel", int'(tap_sel), 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    k_lim = 5;
    push_exp(1, 0, 5, 6, 200, 32'h0144_4444);
    pulse_start();
    wait_empty();

    // 6: start while busy ignored; start on done accepted
    k_lim = 4;
    push_exp(1, 0, 4, 5, 168, 32'h0014_4444);
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    wait_done();
    k_lim = -1;
    push_exp(0, 1, 0, 0, 8, 32'h0000_0001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_locked_clr", int'(locked), 0);
    chk("restart_busy", int'(busy), 1);
    wait_done();
    k_lim = 2;
    push_exp(1, 0, 2, 3, 104, 32'h0000_1444);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_err_clr", int'(err), 0);
    chk("restart_busy2", int'(busy), 1);
    wait_empty();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
